// File: rtl/arst_pipe_pkg.sv
// Shared constants and helpers for the arst_pipe_bank register pipeline.
package arst_pipe_pkg;

    localparam bit EN_ACTIVE_HIGH = 1'b1;
    localparam bit EN_ACTIVE_LOW  = 1'b0;

    localparam int                   DEF_WIDTH   = 6;
    localparam logic [DEF_WIDTH-1:0] DEF_RST_VAL = '0;

    // Width needed to count 0..depth valid stages.
    function automatic int occ_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/arst_pipe_stage.sv
// One pipeline stage: valid and data registers, asynchronously reset to 0 / RST_VAL.
module arst_pipe_stage
    import arst_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Data is captured only with a valid word; a bubble leaves the old data in place.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (load_i) begin
            v_d = up_valid_i;
            if (up_valid_i) begin
                d_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= 1'b0;
            d_q <= RST_VAL;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign valid_o = v_q;
    assign data_o  = d_q;

endmodule

// File: rtl/arst_pipe_bank.sv
// WIDTH x DEPTH elastic pipeline with async reset values, global enable and valid/ready.
// Define ARST_PIPE_BANK_OCC_EN to add the 'occ' occupancy counter output.
module arst_pipe_bank
    import arst_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter bit               EN_POL  = EN_ACTIVE_HIGH
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q
`ifdef ARST_PIPE_BANK_OCC_EN
    ,
    output logic [occ_w(DEPTH)-1:0] occ
`endif
);

    logic             en;
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];

    assign en         = (E == EN_POL);
    assign rdy[DEPTH] = out_ready;

    genvar i;
    for (i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = D;
        end else begin : g_body
            assign up_v = v[i-1];
            assign up_d = d[i-1];
        end

        // A stage can take a word if it is empty or its own word moves on this edge.
        assign rdy[i] = ~v[i] | rdy[i+1];

        arst_pipe_stage #(
            .WIDTH  (WIDTH),
            .RST_VAL(RST_VAL)
        ) u_stage (
            .clk_i     (C),
            .rst_ni    (R),
            .load_i    (en & rdy[i]),
            .up_valid_i(up_v),
            .up_data_i (up_d),
            .valid_o   (v[i]),
            .data_o    (d[i])
        );
    end

    assign in_ready  = R & en & rdy[0];
    assign out_valid = v[DEPTH-1];
    assign Q         = d[DEPTH-1];

`ifdef ARST_PIPE_BANK_OCC_EN
    localparam int OCC_W = occ_w(DEPTH);

    logic             push, pop;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready & en;

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
`endif

endmodule

// File: doc/arst_pipe_bank.md
Name: arst_pipe_bank

Overview:
- Parametrised successor to the single-bit async-reset storage cells: a WIDTH-bit, DEPTH-stage elastic register pipeline.
- Every stage register has a per-bit asynchronous reset value (0 or 1 per bit), set by parameter.
- Adds a global enable with selectable polarity and valid/ready flow control.
- Sits between producer and consumer logic wherever reset-valued, stallable buffering is needed; also serves as a dfflegalize/techmap stress block.

Parameters:
- WIDTH, 6: data bits per stage.
- DEPTH, 3: number of pipeline stages, ≥1.
- RST_VAL, {WIDTH{1'b0}}: per-bit value loaded into every stage's data register on reset.
- EN_POL, 1: enable polarity. 1 = E active-high; 0 = E active-low.

Ports:
- C  in  1  clock, rising edge.
- R  in  1  reset; asynchronous, active-low.
- E  in  1  global enable; polarity per EN_POL.
- in_valid  in  1  producer has data.
- in_ready  out  1  stage 0 can accept.
- D  in  WIDTH  input data.
- out_valid  out  1  last stage holds data.
- out_ready  in  1  consumer accepts.
- Q  out  WIDTH  last-stage data.

Behaviour:
- Reset (R=0): asynchronous, immediate, no clock required.
  - All stage valids clear to 0; all stage data registers load RST_VAL.
  - Q=RST_VAL, out_valid=0, in_ready=0 while R=0.
- After R rises, in_ready follows the combinational rule below from the first edge onward.
- Enable: en = (E == EN_POL).
  - en=0: no register changes on any edge; in_ready=0.
  - out_valid and Q keep showing the held state.
  - out_ready is ignored for transfer accounting.
- Stage i (0..DEPTH-1), with en=1:
  - rdy_i = !v_i | rdy_{i+1}, where rdy_DEPTH = out_ready. Combinational chain; no bubble is required.
  - If rdy_i: v_i ← v_{i-1} and d_i ← d_{i-1} (stage −1 = in_valid/D).
  - Else v_i and d_i hold.
  - A stage loads only when v_{i-1}=1. When rdy_i=1 and v_{i-1}=0, v_i ← 0 and d_i holds its old value (it is not cleared to RST_VAL).
- in_ready = en & rdy_0. out_valid = v_{DEPTH-1}. Q = d_{DEPTH-1}.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready & en.
- Latency: DEPTH cycles from input transfer to out_valid with an empty, unstalled pipe.
- Throughput: 1 word/cycle when out_ready=1 and en=1.
- Full: all v_i=1 and out_ready=0 → in_ready=0; no data lost or overwritten.
- Simultaneous push into a full pipe with a pop (out_ready=1): both transfers occur; the pipe stays full.
- Empty: out_valid=0. Q shows the last held data (RST_VAL if never loaded).
- Reset mid-operation: all in-flight words are discarded asynchronously. No partial state survives.
- in_valid must hold until accepted; a bench assertion checks this. D is sampled only on transfer.

Optional Feature:
- Macro: ARST_PIPE_BANK_OCC_EN.
- Defined:
  - Adds output port occ, width $clog2(DEPTH+1): the count of valid stages.
  - Reset value 0.
  - Updated on the same edge as the valids: +1 on input transfer only, −1 on output transfer only, unchanged on both or neither.
  - Never exceeds DEPTH and never underflows; the bench asserts both.
- Undefined: no occ port and no counter logic. Behaviour is otherwise identical.

Decomposition:
- Package arst_pipe_pkg:
  - occ_w(depth) function.
  - EN_ACTIVE_HIGH / EN_ACTIVE_LOW constants.
  - Default RST_VAL constant.
- Sub-module arst_pipe_stage: one stage containing v/d registers with async active-low reset to RST_VAL/0, load = en & rdy_i.
- Top module generates DEPTH instances and the rdy chain.

Test Plan (WIDTH=6, DEPTH=3, RST_VAL=6'b111000, EN_POL=1 unless stated):
1. Assert R=0 between clock edges → Q=6'b111000, out_valid=0, in_ready=0 immediately, without waiting for an edge.
2. Release R; E=1, out_ready=1; push D=6'h15 in cycle 0 → out_valid=1, Q=6'h15 exactly 3 cycles later. Stream 6'h01..6'h05 back-to-back → outputs in order, one per cycle.
3. Hold out_ready=0 and push 4 words → 3 accepted, in_ready=0 on the 4th. Raise out_ready together with in_valid → push and pop in the same cycle; occ stays 3 with ARST_PIPE_BANK_OCC_EN defined.
4. Mid-stream E=0 for 5 cycles → Q, out_valid and all stages frozen, in_ready=0. Then E=1 → the sequence resumes with nothing dropped or duplicated. Repeat with EN_POL=0 and inverted E.
5. With the pipe full, pulse R low for half a cycle → out_valid=0, Q=6'b111000 at once, occ=0. The next push emerges after 3 cycles.
6. DEPTH=1, RST_VAL=6'b000001: push/pop every cycle with out_ready toggling → no loss and correct backpressure; Q=6'b000001 after reset.
